// File: rtl/exec_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : exec_pkg
//  Purpose  : Shared definitions for the execute stage: opcode encodings,
//             flag bit positions inside flag_ex, and the multiply FSM states.
//  Revision : 1.0  initial parametrised release
// ============================================================================
package exec_pkg;

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_ADC  = 5'b00001;
  localparam logic [4:0] OP_SUB  = 5'b00010;
  localparam logic [4:0] OP_SBB  = 5'b00011;
  localparam logic [4:0] OP_AND  = 5'b00100;
  localparam logic [4:0] OP_OR   = 5'b00101;
  localparam logic [4:0] OP_XOR  = 5'b00110;
  localparam logic [4:0] OP_NOT  = 5'b00111;
  localparam logic [4:0] OP_SHL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_ROL  = 5'b01010;
  localparam logic [4:0] OP_ROR  = 5'b01011;
  localparam logic [4:0] OP_ASR  = 5'b01100;
  localparam logic [4:0] OP_INC  = 5'b01101;
  localparam logic [4:0] OP_DEC  = 5'b01110;
  localparam logic [4:0] OP_PASS = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_MULH = 5'b10001;
  localparam logic [4:0] OP_CMP  = 5'b10010;

  // Bit positions inside flag_ex = {C,Z,S,V}
  localparam int FLAG_C = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_S = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : exec_pkg
`default_nettype wire

// File: rtl/exec_stage_pipe_seq_multiplier.sv
`default_nettype none
// ============================================================================
//  Module   : seq_multiplier
//  Purpose  : Unsigned shift-add multiplier taking DATA_W clock edges.
//             The start edge loads the operands and already folds in bit 0
//             of b; the remaining DATA_W-1 edges fold in one bit each.
//  Ports    : clk, reset (async, active low)
//             start        - load a/b and begin (one-cycle pulse)
//             a, b         - unsigned operands
//             done         - counter has reached DATA_W; product is final
//             product      - 2*DATA_W-bit result
//  Revision : 1.0  initial release
// ============================================================================
module seq_multiplier #(
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic                  done,
  output logic [2*DATA_W-1:0]   product
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

  logic [2*DATA_W-1:0] r_mcand;
  logic [DATA_W-1:0]   r_mplier;
  logic [2*DATA_W-1:0] r_prod;
  logic [CNT_W-1:0]    r_count;

  // A zero count only exists straight out of reset; it and C_LAST both
  // mean "not iterating".
  logic w_running;
  assign w_running = (r_count != '0) && (r_count != C_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_prod   <= '0;
      r_count  <= '0;
    end else if (start) begin
      r_mcand  <= {{(DATA_W-1){1'b0}}, a, 1'b0};
      r_mplier <= {1'b0, b[DATA_W-1:1]};
      r_prod   <= b[0] ? {{DATA_W{1'b0}}, a} : '0;
      r_count  <= C_ONE;
    end else if (w_running) begin
      if (r_mplier[0]) begin
        r_prod <= r_prod + r_mcand;
      end
      r_mcand  <= {r_mcand[2*DATA_W-2:0], 1'b0};
      r_mplier <= {1'b0, r_mplier[DATA_W-1:1]};
      r_count  <= r_count + C_ONE;
    end
  end

  assign done    = (r_count == C_LAST);
  assign product = r_prod;

endmodule : seq_multiplier
`default_nettype wire

// File: rtl/exec_stage_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : exec_stage_pipe
//  Purpose  : Execute stage between decode and memory. Single-cycle ALU,
//             multi-cycle multiply, and the EX pipeline register with a
//             valid/ready handshake upstream and a stall downstream.
//  Ports    : clk, reset (async, active low)
//             valid_dec/ready_dec, op_dec, A, B, data_in, mem_*_dec, RW_dec
//                 - operation from decode
//             stall_ex - memory stage cannot take the current result
//             valid_ex, ans_ex, flag_ex{C,Z,S,V}, data_out, B_Bypass,
//             mem_*_ex, RW_ex - EX pipeline register
//             busy - multiply in progress
//  Revision : 1.0  initial parametrised release
// ============================================================================
module exec_stage_pipe
  import exec_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_dec,
  output logic              ready_dec,
  input  logic [4:0]        op_dec,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic [DATA_W-1:0] data_in,
  input  logic              mem_en_dec,
  input  logic              mem_rw_dec,
  input  logic              mem_mux_sel_dec,
  input  logic [REG_AW-1:0] RW_dec,
  input  logic              stall_ex,
  output logic              valid_ex,
  output logic [DATA_W-1:0] ans_ex,
  output logic [3:0]        flag_ex,
  output logic [DATA_W-1:0] data_out,
  output logic [DATA_W-1:0] B_Bypass,
  output logic              mem_en_ex,
  output logic              mem_rw_ex,
  output logic              mem_mux_sel_ex,
  output logic [REG_AW-1:0] RW_ex,
  output logic              busy
);

  localparam int MSB = DATA_W - 1;
  localparam logic [DATA_W:0] C_ONE_EXT = (DATA_W+1)'(1);

  state_t r_state;
  state_t w_state_next;

  logic r_started;   // holds ready_dec low until the first edge after reset
  logic r_carry;

  // Fields captured when a multiply is accepted
  logic              r_mul_hi;
  logic [DATA_W-1:0] r_mul_b;
  logic [DATA_W-1:0] r_mul_data;
  logic              r_mul_mem_en;
  logic              r_mul_mem_rw;
  logic              r_mul_mux_sel;
  logic [REG_AW-1:0] r_mul_rw;

  logic w_ex_en;
  logic w_accept;
  logic w_is_mul;
  logic w_mul_start;
  logic w_alu_wr;
  logic w_mul_done;
  logic w_mul_wr;
  logic [2*DATA_W-1:0] w_product;

  assign w_ex_en     = !valid_ex || !stall_ex;
  assign ready_dec   = r_started && (r_state == IDLE) && w_ex_en;
  assign w_accept    = valid_dec && ready_dec;
  assign w_is_mul    = (op_dec == OP_MUL) || (op_dec == OP_MULH);
  assign w_mul_start = w_accept && w_is_mul;
  assign w_alu_wr    = w_accept && !w_is_mul;
  assign w_mul_wr    = (r_state == DONE) && w_ex_en;
  assign busy        = (r_state == MUL);

  seq_multiplier #(.DATA_W(DATA_W)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (w_mul_start),
    .a       (A),
    .b       (B),
    .done    (w_mul_done),
    .product (w_product)
  );

  // ---------------------------------------------------------------- ALU
  logic [DATA_W:0]   w_ext;
  logic [DATA_W-1:0] w_res;
  logic [DATA_W-1:0] w_ans;
  logic              w_c;
  logic              w_v;
  logic              w_flag_wr;
  logic              w_ans_is_a;
  logic [3:0]        w_alu_flags;

  always_comb begin
    w_ext      = '0;
    w_res      = '0;
    w_c        = 1'b0;
    w_v        = 1'b0;
    w_flag_wr  = 1'b1;
    w_ans_is_a = 1'b0;
    case (op_dec)
      OP_ADD, OP_ADC: begin
        w_ext = {1'b0, A} + {1'b0, B} +
                ((op_dec == OP_ADC) ? {{DATA_W{1'b0}}, r_carry} : '0);
        {w_c, w_res} = w_ext;
        w_v = (A[MSB] == B[MSB]) && (w_res[MSB] != A[MSB]);
      end
      OP_SUB, OP_SBB, OP_CMP: begin
        // Top bit of the extended difference is the borrow.
        w_ext = {1'b0, A} - {1'b0, B} -
                ((op_dec == OP_SBB) ? {{DATA_W{1'b0}}, r_carry} : '0);
        {w_c, w_res} = w_ext;
        w_v = (A[MSB] != B[MSB]) && (w_res[MSB] != A[MSB]);
        w_ans_is_a = (op_dec == OP_CMP);
      end
      OP_AND:  w_res = A & B;
      OP_OR:   w_res = A | B;
      OP_XOR:  w_res = A ^ B;
      OP_NOT:  w_res = ~A;
      OP_SHL: begin w_res = {A[MSB-1:0], 1'b0};   w_c = A[MSB]; end
      OP_SHR: begin w_res = {1'b0, A[MSB:1]};     w_c = A[0];   end
      OP_ROL: begin w_res = {A[MSB-1:0], A[MSB]}; w_c = A[MSB]; end
      OP_ROR: begin w_res = {A[0], A[MSB:1]};     w_c = A[0];   end
      OP_ASR: begin w_res = {A[MSB], A[MSB:1]};   w_c = A[0];   end
      OP_INC: begin
        w_ext = {1'b0, A} + C_ONE_EXT;
        {w_c, w_res} = w_ext;
        w_v = !A[MSB] && w_res[MSB];
      end
      OP_DEC: begin
        w_ext = {1'b0, A} - C_ONE_EXT;
        {w_c, w_res} = w_ext;
        w_v = A[MSB] && !w_res[MSB];
      end
      OP_PASS: w_res = A;
      default: w_flag_wr = 1'b0;  // NOP: zero result, flags untouched
    endcase
    w_ans = w_ans_is_a ? A : w_res;
    w_alu_flags = '0;
    w_alu_flags[FLAG_C] = w_c;
    w_alu_flags[FLAG_Z] = (w_res == '0);
    w_alu_flags[FLAG_S] = w_res[MSB];
    w_alu_flags[FLAG_V] = w_v;
  end

  // ------------------------------------------------------ multiply result
  logic [DATA_W-1:0] w_mul_val;
  logic [3:0]        w_mul_flags;

  always_comb begin
    w_mul_val = r_mul_hi ? w_product[2*DATA_W-1:DATA_W] : w_product[DATA_W-1:0];
    w_mul_flags = '0;
    w_mul_flags[FLAG_C] = (w_product[2*DATA_W-1:DATA_W] != '0);
    w_mul_flags[FLAG_Z] = (w_mul_val == '0);
    w_mul_flags[FLAG_S] = w_mul_val[MSB];
    w_mul_flags[FLAG_V] = 1'b0;
  end

  // ---------------------------------------------------------------- FSM
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_mul_start) w_state_next = MUL;
      MUL:     if (w_mul_done)  w_state_next = DONE;
      DONE:    if (w_ex_en)     w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_started <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_started <= 1'b1;
    end
  end

  // ------------------------------------------- multiply capture + carry
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_carry       <= 1'b0;
      r_mul_hi      <= 1'b0;
      r_mul_b       <= '0;
      r_mul_data    <= '0;
      r_mul_mem_en  <= 1'b0;
      r_mul_mem_rw  <= 1'b0;
      r_mul_mux_sel <= 1'b0;
      r_mul_rw      <= '0;
    end else begin
      if (w_mul_start) begin
        r_mul_hi      <= (op_dec == OP_MULH);
        r_mul_b       <= B;
        r_mul_data    <= data_in;
        r_mul_mem_en  <= mem_en_dec;
        r_mul_mem_rw  <= mem_rw_dec;
        r_mul_mux_sel <= mem_mux_sel_dec;
        r_mul_rw      <= RW_dec;
      end
      if (w_alu_wr && w_flag_wr) begin
        r_carry <= w_c;
      end else if (w_mul_wr) begin
        r_carry <= w_mul_flags[FLAG_C];
      end
    end
  end

  // --------------------------------------------------------- EX register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_ex       <= 1'b0;
      ans_ex         <= '0;
      flag_ex        <= '0;
      data_out       <= '0;
      B_Bypass       <= '0;
      mem_en_ex      <= 1'b0;
      mem_rw_ex      <= 1'b0;
      mem_mux_sel_ex <= 1'b0;
      RW_ex          <= '0;
    end else if (w_ex_en) begin
      if (w_alu_wr) begin
        valid_ex       <= 1'b1;
        ans_ex         <= w_ans;
        if (w_flag_wr) begin
          flag_ex <= w_alu_flags;
        end
        data_out       <= data_in;
        B_Bypass       <= B;
        mem_en_ex      <= mem_en_dec;
        mem_rw_ex      <= mem_rw_dec;
        mem_mux_sel_ex <= mem_mux_sel_dec;
        RW_ex          <= RW_dec;
      end else if (r_state == DONE) begin
        valid_ex       <= 1'b1;
        ans_ex         <= w_mul_val;
        flag_ex        <= w_mul_flags;
        data_out       <= r_mul_data;
        B_Bypass       <= r_mul_b;
        mem_en_ex      <= r_mul_mem_en;
        mem_rw_ex      <= r_mul_mem_rw;
        mem_mux_sel_ex <= r_mul_mux_sel;
        RW_ex          <= r_mul_rw;
      end else begin
        // Bubble: drop valid, keep the data fields as they were.
        valid_ex <= 1'b0;
      end
    end
  end

endmodule : exec_stage_pipe
`default_nettype wire
